hazard_scoreboard: RTL and testbench

- Parametrised successor to the ID/EX hazard-detect logic. Replaces fixed load-use comparison against one pipeline stage with a per-register scoreboard of countdown timers.
- Supports variable result latency: ALU 0, load 1, multi-cycle mul/div up to MAX_LAT.
- Sits in ID. Decides each cycle whether the decoding instruction may issue, stalls it, or flushes it on a taken branch.
- Also enforces WAW ordering and freezes under external pipeline stalls.

---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: one countdown timer per architectural register for RAW/WAW stalls and branch flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32,
    parameter int LAT_W    = 3,
    parameter int MAX_LAT  = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              branch_taken,
    input  logic              ext_stall,
    output logic              stall,
    output logic              flush,
    output logic              issue,
    output logic              busy_any
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_raw_stalls,
    output logic [31:0]       perf_waw_stalls,
    output logic [31:0]       perf_flushes
`endif
);

    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] lat_eff;
    logic             raw;
    logic             waw;
    logic             load_en;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        return (lat > MAX_LAT_V) ? MAX_LAT_V : lat;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_comb begin
        lat_eff = clamp_lat(id_lat);
        raw     = (id_rs1_used && (cnt_q[id_rs1] != '0)) ||
                  (id_rs2_used && (cnt_q[id_rs2] != '0));
        waw     = id_rd_we && (id_rd != '0) && (cnt_q[id_rd] > lat_eff);
        flush   = branch_taken;
        stall   = !branch_taken && (ext_stall || (id_valid && (raw || waw)));
        issue   = id_valid && !stall && !flush;
        load_en = issue && id_rd_we && (id_rd != '0) && (lat_eff != '0);
    end

    always_comb begin
        busy_any = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_any = busy_any | (cnt_q[r] != '0);
        end
    end

    // Entry 0 is held at zero so x0 never looks pending; a new issue overrides the decrement.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!rstn || r == 0) begin
                cnt_q[r] <= '0;
            end else if (!ext_stall) begin
                if (load_en && (id_rd == REG_AW'(r))) begin
                    cnt_q[r] <= lat_eff;
                end else if (cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // A stall with both hazards present is attributed to RAW only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_raw_stalls <= '0;
            perf_waw_stalls <= '0;
            perf_flushes    <= '0;
        end else begin
            if (stall && id_valid && raw) begin
                perf_raw_stalls <= sat_inc(perf_raw_stalls);
            end
            if (stall && id_valid && waw && !raw) begin
                perf_waw_stalls <= sat_inc(perf_waw_stalls);
            end
            if (flush) begin
                perf_flushes <= sat_inc(perf_flushes);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard: per-cycle stimulus with hand-derived expected outputs.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rstn, id_valid, id_rs1_used, id_rs2_used, id_rd_we, branch_taken, ext_stall;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [2:0] id_lat;
    logic       stall, flush, issue, busy_any;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_raw_stalls, perf_waw_stalls, perf_flushes;
`endif

    hazard_scoreboard #(.REG_AW(5), .NUM_REGS(32), .LAT_W(3), .MAX_LAT(6)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat(id_lat),
        .branch_taken(branch_taken), .ext_stall(ext_stall),
        .stall(stall), .flush(flush), .issue(issue), .busy_any(busy_any)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_raw_stalls(perf_raw_stalls), .perf_waw_stalls(perf_waw_stalls),
        .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstn, val;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       we;
        logic [2:0] lat;
        logic       br, ext;
        logic       chk, s, f, i, b;
    } vec_t;

    typedef struct {
        int   idx;
        logic chk, s, f, i, b;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input int rs, input int val, input int rs1, input int u1,
                                input int rs2, input int u2, input int rd, input int we,
                                input int lat, input int br, input int ext,
                                input int s, input int f, input int i, input int b);
        vec_t v;
        v.rstn = rs[0];  v.val = val[0];
        v.rs1  = rs1[4:0]; v.u1 = u1[0];
        v.rs2  = rs2[4:0]; v.u2 = u2[0];
        v.rd   = rd[4:0];  v.we = we[0];
        v.lat  = lat[2:0]; v.br = br[0]; v.ext = ext[0];
        v.chk  = 1'b1;
        v.s = s[0]; v.f = f[0]; v.i = i[0]; v.b = b[0];
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        rstn = v.rstn; id_valid = v.val;
        id_rs1 = v.rs1; id_rs1_used = v.u1;
        id_rs2 = v.rs2; id_rs2_used = v.u2;
        id_rd = v.rd; id_rd_we = v.we; id_lat = v.lat;
        branch_taken = v.br; ext_stall = v.ext;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int   stalls;
        logic got_issue;

        // Reset for two cycles; the first cycle's outputs depend on pre-reset state.
        v = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0); v.chk = 1'b0; vecs.push_back(v);
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
        // Load-use on x5 with lat=1, then lat=0
        vecs.push_back(mk(1,1,0,0,0,0,5,1,1,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,5,1,0,0,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,5,1,0,0,0,0,0,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,5,1,0,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,5,1,0,0,0,0,0,0,0, 0,0,1,0));
        // WAW on x7: lat 4 then lat 1; stalls while cnt > 1
        vecs.push_back(mk(1,1,0,0,0,0,7,1,4,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,7,1,1,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,7,1,1,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,7,1,1,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,7,1,1,0,0, 0,0,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
        // x3 lat 3 frozen by ext_stall for 5 cycles, then consumer on rs2
        vecs.push_back(mk(1,1,0,0,0,0,3,1,3,0,0, 0,0,1,0));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,3,1,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,3,1,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,3,1,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,3,1,0,0,0,0,0, 0,0,1,0));
        // Branch flush over a RAW hazard: counters keep decrementing
        vecs.push_back(mk(1,1,0,0,0,0,10,1,2,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,10,1,0,0,0,0,0,1,0, 0,1,0,1));
        vecs.push_back(mk(1,1,10,1,0,0,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,10,1,0,0,0,0,0,0,0, 0,0,1,0));
        // Branch with ext_stall: flush wins, counters frozen
        vecs.push_back(mk(1,1,0,0,0,0,10,1,2,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,10,1,0,0,0,0,0,1,1, 0,1,0,1));
        vecs.push_back(mk(1,1,10,1,0,0,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,10,1,0,0,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,10,1,0,0,0,0,0,0,0, 0,0,1,0));
        // lat 7 clamped to 6 on x9; writes to x0 ignored
        vecs.push_back(mk(1,1,0,0,0,0,9,1,7,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,6,0,0, 0,0,1,1));
        vecs.push_back(mk(1,1,0,1,0,1,0,0,0,0,0, 0,0,1,1));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1,1,9,1,0,0,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,9,1,0,0,0,0,0,0,0, 0,0,1,0));
        // Source equals rd in the same cycle; concurrent decrement-to-zero and new load
        vecs.push_back(mk(1,1,12,1,0,0,12,1,3,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,13,1,1,0,0, 0,0,1,1));
        vecs.push_back(mk(1,1,0,0,0,0,14,1,2,0,0, 0,0,1,1));
        vecs.push_back(mk(1,1,13,1,0,0,0,0,0,0,0, 0,0,1,1));
        vecs.push_back(mk(1,1,0,0,14,1,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,14,1,0,0,0,0,0, 0,0,1,0));
        // Reset mid-operation drops pending x20
        vecs.push_back(mk(1,1,0,0,0,0,20,1,5,0,0, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,1));
        vecs.push_back(mk(1,1,20,1,0,0,0,0,0,0,0, 0,0,1,0));

        for (int n = 0; n < vecs.size(); n++) begin
            @(posedge clk);
            #1;
            drive(vecs[n]);
            e.idx = n; e.chk = vecs[n].chk;
            e.s = vecs[n].s; e.f = vecs[n].f; e.i = vecs[n].i; e.b = vecs[n].b;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            if (e.chk) begin
                check("stall", e.idx, stall, e.s);
                check("flush", e.idx, flush, e.f);
                check("issue", e.idx, issue, e.i);
                check("busy_any", e.idx, busy_any, e.b);
            end
        end

        // Longest latency: consumer of x17 (lat 6) should stall exactly 6 cycles.
        @(posedge clk);
        #1;
        drive(mk(1,1,0,0,0,0,17,1,6,0,0, 0,0,1,0));
        @(negedge clk);
        check("lat6_issue", 100, issue, 1'b1);
        @(posedge clk);
        #1;
        drive(mk(1,1,17,1,0,0,0,0,0,0,0, 0,0,0,0));
        stalls = 0;
        got_issue = 1'b0;
        for (int k = 0; k < 20 && !got_issue; k++) begin
            @(negedge clk);
            if (issue) got_issue = 1'b1;
            else stalls++;
        end
        check("lat6_released", 101, got_issue, 1'b1);
        n_tests++;
        if (stalls != 6) begin
            n_fail++;
            $display("FAIL lat6_stall_cycles actual=%0d required=6", stalls);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
